// File: rtl/calc_sched_pkg.sv
// Shared constants, state encoding and command helper for the calc1 port scheduler.
// The command check helper is only used when CALC_SCHED_CMD_CHECK_EN is defined.
package calc_sched_pkg;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;
   localparam logic [1:0] RESP_TMO  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OP1,
      ST_OP2,
      ST_WAIT,
      ST_DONE
   } sched_state_t;

   function automatic logic cmd_supported(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
   endfunction

endpackage

// File: rtl/calc_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr
// and reports the pointer value that follows the winner.
module calc_rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] next_ptr
);

   logic found;

   // First pass covers ptr..N-1, second pass wraps around to 0..ptr-1.
   always_comb begin
      gnt      = '0;
      next_ptr = ptr;
      found    = 1'b0;
      for (int unsigned j = 0; j < N; j++) begin
         if (!found && req[j] && (j >= 32'(ptr))) begin
            found    = 1'b1;
            gnt[j]   = 1'b1;
            next_ptr = PW'((j + 1) % N);
         end
      end
      for (int unsigned j = 0; j < N; j++) begin
         if (!found && req[j]) begin
            found    = 1'b1;
            gnt[j]   = 1'b1;
            next_ptr = PW'((j + 1) % N);
         end
      end
   end

endmodule

// File: rtl/calc_port_sched.sv
// Shares one calc1 request port among NUM_CLIENTS requesters, round-robin.
// Optional macro CALC_SCHED_CMD_CHECK_EN rejects unsupported commands locally.
module calc_port_sched
   import calc_sched_pkg::*;
#(
   parameter int unsigned NUM_CLIENTS = 4,
   parameter int unsigned TIMEOUT     = 15
) (
   input  logic                      c_clk,
   input  logic                      reset,
   input  logic [NUM_CLIENTS-1:0]    cli_req,
   input  logic [NUM_CLIENTS*4-1:0]  cli_cmd,
   input  logic [NUM_CLIENTS*32-1:0] cli_op1,
   input  logic [NUM_CLIENTS*32-1:0] cli_op2,
   output logic [NUM_CLIENTS-1:0]    cli_gnt,
   output logic [NUM_CLIENTS-1:0]    cli_done,
   output logic [1:0]                cli_resp,
   output logic [31:0]               cli_data,
   output logic [3:0]                calc_cmd_out,
   output logic [31:0]               calc_data_out,
   input  logic [1:0]                calc_resp_in,
   input  logic [31:0]               calc_data_in
);

   localparam int unsigned PW = $clog2(NUM_CLIENTS);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   sched_state_t           state;
   logic [PW-1:0]          ptr;
   logic [NUM_CLIENTS-1:0] arb_gnt;
   logic [PW-1:0]          arb_next;
   logic [3:0]             sel_cmd;
   logic [31:0]            sel_op1;
   logic [31:0]            sel_op2;
   logic [NUM_CLIENTS-1:0] hold_sel;
   logic [31:0]            hold_op2;
   logic [1:0]             hold_resp;
   logic [31:0]            hold_data;
   logic [CW-1:0]          cnt;

   calc_rr_arbiter #(.N(NUM_CLIENTS)) u_arb (
      .req      (cli_req),
      .ptr      (ptr),
      .gnt      (arb_gnt),
      .next_ptr (arb_next)
   );

   always_comb begin
      sel_cmd = '0;
      sel_op1 = '0;
      sel_op2 = '0;
      for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
         if (arb_gnt[j]) begin
            sel_cmd = cli_cmd[4*j +: 4];
            sel_op1 = cli_op1[32*j +: 32];
            sel_op2 = cli_op2[32*j +: 32];
         end
      end
   end

   // Outputs are registered with the value belonging to the state being entered,
   // so the calc port shows cmd/op1 while in OP1 and op2 while in OP2.
   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         ptr           <= '0;
         cnt           <= '0;
         hold_sel      <= '0;
         hold_op2      <= '0;
         hold_resp     <= RESP_NONE;
         hold_data     <= '0;
         cli_gnt       <= '0;
         cli_done      <= '0;
         cli_resp      <= RESP_NONE;
         cli_data      <= '0;
         calc_cmd_out  <= CMD_NOP;
         calc_data_out <= '0;
      end else begin
         cli_gnt  <= '0;
         cli_done <= '0;
         cli_resp <= RESP_NONE;
         cli_data <= '0;
         unique case (state)
            ST_IDLE: begin
               if (|cli_req) begin
                  cli_gnt  <= arb_gnt;
                  hold_sel <= arb_gnt;
                  hold_op2 <= sel_op2;
                  ptr      <= arb_next;
`ifdef CALC_SCHED_CMD_CHECK_EN
                  if (!cmd_supported(sel_cmd)) begin
                     hold_resp <= RESP_ERR;
                     hold_data <= '0;
                     state     <= ST_DONE;
                  end else begin
                     calc_cmd_out  <= sel_cmd;
                     calc_data_out <= sel_op1;
                     state         <= ST_OP1;
                  end
`else
                  calc_cmd_out  <= sel_cmd;
                  calc_data_out <= sel_op1;
                  state         <= ST_OP1;
`endif
               end
            end
            ST_OP1: begin
               calc_cmd_out  <= CMD_NOP;
               calc_data_out <= hold_op2;
               state         <= ST_OP2;
            end
            ST_OP2: begin
               calc_cmd_out  <= CMD_NOP;
               calc_data_out <= '0;
               cnt           <= '0;
               state         <= ST_WAIT;
            end
            ST_WAIT: begin
               // A response on the final counted cycle takes priority over the timeout.
               if (calc_resp_in != RESP_NONE) begin
                  hold_resp <= calc_resp_in;
                  hold_data <= calc_data_in;
                  state     <= ST_DONE;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  cnt       <= cnt + 1'b1;
                  hold_resp <= RESP_TMO;
                  hold_data <= '0;
                  state     <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               cli_done <= hold_sel;
               cli_resp <= hold_resp;
               cli_data <= hold_data;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_port_sched.sv
// Directed bench for calc_port_sched with a small calc1 response model.
// Honors CALC_SCHED_CMD_CHECK_EN for the unsupported-command vector.
module tb_calc_port_sched;
   import calc_sched_pkg::*;

   localparam int unsigned NC  = 4;
   localparam int unsigned TMO = 15;
`ifdef CALC_SCHED_CMD_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic              c_clk = 1'b0;
   logic              reset = 1'b1;
   logic [NC-1:0]     cli_req = '0;
   logic [NC*4-1:0]   cli_cmd = '0;
   logic [NC*32-1:0]  cli_op1 = '0;
   logic [NC*32-1:0]  cli_op2 = '0;
   logic [NC-1:0]     cli_gnt;
   logic [NC-1:0]     cli_done;
   logic [1:0]        cli_resp;
   logic [31:0]       cli_data;
   logic [3:0]        calc_cmd_out;
   logic [31:0]       calc_data_out;
   logic [1:0]        calc_resp_in = '0;
   logic [31:0]       calc_data_in = '0;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   calc_port_sched #(.NUM_CLIENTS(NC), .TIMEOUT(TMO)) dut (
      .c_clk         (c_clk),
      .reset         (reset),
      .cli_req       (cli_req),
      .cli_cmd       (cli_cmd),
      .cli_op1       (cli_op1),
      .cli_op2       (cli_op2),
      .cli_gnt       (cli_gnt),
      .cli_done      (cli_done),
      .cli_resp      (cli_resp),
      .cli_data      (cli_data),
      .calc_cmd_out  (calc_cmd_out),
      .calc_data_out (calc_data_out),
      .calc_resp_in  (calc_resp_in),
      .calc_data_in  (calc_data_in)
   );

   always #5 c_clk = ~c_clk;

   // calc1 stand-in: captures cmd/op1 then op2, answers m_delay cycles into WAIT.
   int unsigned m_st = 0, m_cnt = 0, m_delay = 0, m_seen = 0;
   bit          m_silent = 1'b0;
   logic [3:0]  m_cmd = '0;
   logic [31:0] m_op1 = '0, m_op2 = '0;

   function automatic logic [33:0] calc_ref(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      case (cmd)
         CMD_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            return s[32] ? {RESP_ERR, 32'h0} : {RESP_OK, s[31:0]};
         end
         CMD_SUB: return (a < b) ? {RESP_ERR, 32'h0} : {RESP_OK, a - b};
         CMD_SHL: return {RESP_OK, a << b[4:0]};
         CMD_SHR: return {RESP_OK, a >> b[4:0]};
         default: return {RESP_ERR, 32'h0};
      endcase
   endfunction

   always @(negedge c_clk) begin
      if (reset) begin
         m_st = 0;
         calc_resp_in = '0;
         calc_data_in = '0;
      end else begin
         case (m_st)
            0: begin
               calc_resp_in = '0;
               calc_data_in = '0;
               if (calc_cmd_out != CMD_NOP) begin
                  m_cmd = calc_cmd_out;
                  m_op1 = calc_data_out;
                  m_seen++;
                  m_st = 1;
               end
            end
            1: begin
               m_op2 = calc_data_out;
               m_cnt = 0;
               m_st  = m_silent ? 0 : 2;
            end
            default: begin
               if (m_cnt == m_delay) begin
                  {calc_resp_in, calc_data_in} = calc_ref(m_cmd, m_op1, m_op2);
                  m_st = 0;
               end else begin
                  m_cnt++;
               end
            end
         endcase
      end
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   function automatic void bound_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no event within the cycle budget, expected one", name);
   endfunction

   task automatic do_op(input string tag, input int unsigned c, input logic [3:0] cmd,
                        input logic [31:0] a, input logic [31:0] b, input int unsigned dly,
                        input bit silent, input logic [1:0] e_resp, input logic [31:0] e_data,
                        input int unsigned e_lat, input bit e_fwd);
      int unsigned n, seen0;
      m_delay  = dly;
      m_silent = silent;
      seen0    = m_seen;
      @(negedge c_clk);
      cli_req[c]         = 1'b1;
      cli_cmd[4*c +: 4]  = cmd;
      cli_op1[32*c +: 32] = a;
      cli_op2[32*c +: 32] = b;
      n = 0;
      while (cli_gnt == '0 && n < 20) begin
         @(negedge c_clk);
         n++;
      end
      if (cli_gnt == '0) begin
         bound_fail({tag, "_gnt"});
         cli_req[c] = 1'b0;
         return;
      end
      check({tag, "_gnt"}, 32'(cli_gnt), 32'(1) << c);
      // Changing inputs after the grant must not affect the captured operation.
      cli_req[c]          = 1'b0;
      cli_cmd[4*c +: 4]   = 4'hF;
      cli_op1[32*c +: 32] = ~a;
      cli_op2[32*c +: 32] = ~b;
      n = 0;
      while (cli_done == '0 && n < 40) begin
         @(negedge c_clk);
         n++;
      end
      if (cli_done == '0) begin
         bound_fail({tag, "_done"});
         return;
      end
      check({tag, "_done"}, 32'(cli_done), 32'(1) << c);
      check({tag, "_resp"}, 32'(cli_resp), 32'(e_resp));
      check({tag, "_data"}, cli_data, e_data);
      check({tag, "_lat"}, n, e_lat);
      if (e_fwd) begin
         check({tag, "_calc_cmd"}, 32'(m_cmd), 32'(cmd));
         check({tag, "_calc_op1"}, m_op1, a);
         check({tag, "_calc_op2"}, m_op2, b);
         check({tag, "_calc_seen"}, m_seen, seen0 + 1);
      end else begin
         check({tag, "_calc_idle"}, m_seen, seen0);
      end
      @(negedge c_clk);
      check({tag, "_done_pulse"}, 32'(cli_done), 32'h0);
      check({tag, "_data_clr"}, cli_data, 32'h0);
   endtask

   typedef struct {
      int unsigned c;
      logic [3:0]  cmd;
      logic [31:0] a;
      logic [31:0] b;
      int unsigned dly;
      logic [1:0]  resp;
      logic [31:0] data;
   } vec_t;

   vec_t vt [8];

   initial begin
      int unsigned n, gi, di, busy;
      vt[0] = '{2, CMD_ADD, 32'hFFFF_FFFF, 32'h1,  0,  RESP_ERR, 32'h0};
      vt[1] = '{1, CMD_SUB, 32'd10,        32'd3,  2,  RESP_OK,  32'd7};
      vt[2] = '{0, CMD_SUB, 32'd3,         32'd10, 1,  RESP_ERR, 32'h0};
      vt[3] = '{2, CMD_SHL, 32'h1,         32'd4,  0,  RESP_OK,  32'h10};
      vt[4] = '{1, CMD_SHR, 32'h8000_0000, 32'd31, 3,  RESP_OK,  32'h1};
      vt[5] = '{0, CMD_ADD, 32'h1234,      32'h4321, 14, RESP_OK, 32'h5555};
      vt[6] = '{3, 4'd3,    32'd7,         32'd8,  0,  RESP_ERR, 32'h0};
      vt[7] = '{3, CMD_ADD, 32'd2,         32'd3,  0,  RESP_OK,  32'd5};

      repeat (3) @(negedge c_clk);
      check("rst_gnt",  32'(cli_gnt), 32'h0);
      check("rst_done", 32'(cli_done), 32'h0);
      check("rst_resp", 32'(cli_resp), 32'h0);
      check("rst_data", cli_data, 32'h0);
      check("rst_ccmd", 32'(calc_cmd_out), 32'h0);
      check("rst_cdat", calc_data_out, 32'h0);
      reset = 1'b0;

      do_op("single", 0, CMD_ADD, 32'h1, 32'h01FF_FFFF, 0, 1'b0, RESP_OK, 32'h0200_0000, 4, 1'b1);

      for (int i = 0; i < 8; i++) begin
         if (vt[i].cmd == 4'd3 && CHK_EN)
            do_op($sformatf("vec%0d", i), vt[i].c, vt[i].cmd, vt[i].a, vt[i].b, vt[i].dly,
                  1'b0, vt[i].resp, vt[i].data, 1, 1'b0);
         else
            do_op($sformatf("vec%0d", i), vt[i].c, vt[i].cmd, vt[i].a, vt[i].b, vt[i].dly,
                  1'b0, vt[i].resp, vt[i].data, 4 + vt[i].dly, 1'b1);
      end

      // All four clients at once with pointer at 0: grants 0,1,2,3.
      m_delay  = 0;
      m_silent = 1'b0;
      @(negedge c_clk);
      for (int unsigned j = 0; j < NC; j++) begin
         cli_req[j]          = 1'b1;
         cli_cmd[4*j +: 4]   = CMD_ADD;
         cli_op1[32*j +: 32] = j;
         cli_op2[32*j +: 32] = j;
      end
      gi = 0; di = 0; n = 0;
      while ((gi < NC || di < NC) && n < 100) begin
         @(negedge c_clk);
         n++;
         if (cli_gnt != '0) begin
            check($sformatf("cont_gnt%0d", gi), 32'(cli_gnt), 32'(1) << gi);
            for (int unsigned j = 0; j < NC; j++) begin
               if (cli_gnt[j]) begin
                  cli_req[j]          = 1'b0;
                  cli_op1[32*j +: 32] = 32'hDEAD_0000;
               end
            end
            gi++;
         end
         if (cli_done != '0) begin
            check($sformatf("cont_done%0d", di), 32'(cli_done), 32'(1) << di);
            check($sformatf("cont_resp%0d", di), 32'(cli_resp), 32'(RESP_OK));
            check($sformatf("cont_data%0d", di), cli_data, 2 * di);
            di++;
         end
      end
      if (gi < NC || di < NC) bound_fail("cont_all");
      cli_req = '0;

      do_op("tmo", 1, CMD_ADD, 32'd5, 32'd6, 0, 1'b1, RESP_TMO, 32'h0, 3 + TMO, 1'b1);
      do_op("after_tmo", 2, CMD_ADD, 32'd2, 32'd3, 0, 1'b0, RESP_OK, 32'd5, 4, 1'b1);

      // Reset while calc1 is being driven; client 1 grant moves the pointer to 2.
      m_silent = 1'b1;
      @(negedge c_clk);
      cli_req[1]        = 1'b1;
      cli_cmd[7:4]      = CMD_ADD;
      cli_op1[63:32]    = 32'hAAAA;
      cli_op2[63:32]    = 32'h5555;
      n = 0;
      while (cli_gnt == '0 && n < 20) begin
         @(negedge c_clk);
         n++;
      end
      if (cli_gnt == '0) bound_fail("rstmid_gnt");
      check("rstmid_pre_cmd", 32'(calc_cmd_out), 32'(CMD_ADD));
      cli_req = '0;
      #2 reset = 1'b1;
      #1;
      check("rstmid_ccmd", 32'(calc_cmd_out), 32'h0);
      check("rstmid_cdat", calc_data_out, 32'h0);
      check("rstmid_gnt0", 32'(cli_gnt), 32'h0);
      check("rstmid_done", 32'(cli_done), 32'h0);
      check("rstmid_resp", 32'(cli_resp), 32'h0);
      check("rstmid_data", cli_data, 32'h0);
      repeat (2) @(negedge c_clk);
      reset    = 1'b0;
      m_silent = 1'b0;
      busy = 0;
      repeat (25) begin
         @(negedge c_clk);
         if (cli_done != '0) busy++;
      end
      check("rstmid_no_done", busy, 0);
      cli_req[0]      = 1'b1;
      cli_cmd[3:0]    = CMD_ADD;
      cli_op1[31:0]   = 32'd4;
      cli_op2[31:0]   = 32'd9;
      cli_req[3]      = 1'b1;
      cli_cmd[15:12]  = CMD_ADD;
      n = 0;
      while (cli_gnt == '0 && n < 20) begin
         @(negedge c_clk);
         n++;
      end
      if (cli_gnt == '0) bound_fail("rstptr_gnt");
      check("rstptr_gnt", 32'(cli_gnt), 32'h1);
      cli_req = '0;
      n = 0;
      while (cli_done == '0 && n < 40) begin
         @(negedge c_clk);
         n++;
      end
      if (cli_done == '0) bound_fail("rstptr_done");
      check("rstptr_done", 32'(cli_done), 32'h1);
      check("rstptr_data", cli_data, 32'd13);

      repeat (3) @(negedge c_clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1);
   end

endmodule
